// File: rtl/kernel_pr_fifo_param_s.sv
// Parametrised shift-register FIFO with first-word-fall-through, occupancy count,
// programmable almost-full/almost-empty flags and a synchronous flush.
module kernel_pr_fifo_param_s #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
    parameter int unsigned AF_THRESH  = DEPTH - 1,
    parameter int unsigned AE_THRESH  = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           if_flush,
    output logic                           if_empty_n,
    input  logic                           if_read_ce,
    input  logic                           if_read,
    output logic [DATA_WIDTH-1:0]          if_dout,
    output logic                           if_full_n,
    input  logic                           if_write_ce,
    input  logic                           if_write,
    input  logic [DATA_WIDTH-1:0]          if_din,
    output logic [$clog2(DEPTH+1)-1:0]     if_count,
    output logic                           if_almost_full,
    output logic                           if_almost_empty
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [CW-1:0]         count_q, count_d;
    logic                  empty_n_q, empty_n_d;
    logic                  full_n_q, full_n_d;
    logic                  af_q, af_d;
    logic                  ae_q, ae_d;
    logic                  rd, wr;
    logic [ADDR_WIDTH-1:0] raddr;

    always_comb begin
        rd      = if_read & if_read_ce & empty_n_q;
        wr      = if_write & if_write_ce & full_n_q;
        mem_d   = mem_q;
        count_d = count_q;
        // Reset and flush both drop any concurrent transfer and freeze storage.
        if (reset || if_flush) begin
            count_d = '0;
        end else begin
            if (wr) begin
                mem_d[0] = if_din;
                for (int i = 1; i < int'(DEPTH); i++) begin
                    mem_d[i] = mem_q[i-1];
                end
            end
            case ({rd, wr})
                2'b10:   count_d = count_q - CW'(1);
                2'b01:   count_d = count_q + CW'(1);
                default: count_d = count_q;
            endcase
        end
        empty_n_d = (count_d != '0);
        full_n_d  = (count_d != CW'(DEPTH));
        af_d      = (count_d >= CW'(AF_THRESH));
        ae_d      = (count_d <= CW'(AE_THRESH));
    end

    // Oldest entry sits at count-1 because new data always enters at index 0.
    always_comb begin
        raddr = (count_q == '0) ? '0 : ADDR_WIDTH'(count_q - CW'(1));
    end

    always_ff @(posedge clk) begin
        mem_q     <= mem_d;
        count_q   <= count_d;
        empty_n_q <= empty_n_d;
        full_n_q  <= full_n_d;
        af_q      <= af_d;
        ae_q      <= ae_d;
    end

    assign if_dout         = mem_q[raddr];
    assign if_count        = count_q;
    assign if_empty_n      = empty_n_q;
    assign if_full_n       = full_n_q;
    assign if_almost_full  = af_q;
    assign if_almost_empty = ae_q;

endmodule
